// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers for the execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle MULT/MULTU.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [5:0]  alu_op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        stall_o,
    output logic [31:0] result_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    localparam logic [5:0] OP_MFHI = 6'h10;
    localparam logic [5:0] OP_MTHI = 6'h11;
    localparam logic [5:0] OP_MFLO = 6'h12;
    localparam logic [5:0] OP_MTLO = 6'h13;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] hi, lo;
    logic [63:0] acc;
    logic [32:0] rem;
    logic [31:0] opb;
    logic [4:0]  count;
    logic        neg_a, neg_b, div0;

    logic        is_md, is_signed, is_div, start;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign is_md     = valid_i && (alu_op_i[5:2] == 4'b0110);
    assign is_signed = !alu_op_i[0];
    assign is_div    = alu_op_i[1];
    assign start     = is_md && (state == IDLE);
    assign busy_o    = (state == MUL) || (state == DIV);
    assign stall_o   = start || busy_o;

    assign rs_neg = is_signed && rs_data_i[31];
    assign rt_neg = is_signed && rt_data_i[31];
    assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

    // Shift-add step: acc[31:0] holds the remaining multiplier bits.
    logic [32:0] mul_sum;
    logic [63:0] acc_mul;
    logic [63:0] prod;
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign acc_mul = {mul_sum, acc[31:1]};
    assign prod    = (neg_a ^ neg_b) ? -acc_mul : acc_mul;

    // Restoring step: acc[31:0] shifts dividend bits out, quotient bits in.
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt;
    assign shifted = {rem[31:0], acc[31]};
    assign diff    = {1'b0, shifted} - {2'b00, opb};
    assign rem_nxt = diff[33] ? shifted : diff[32:0];
    assign quo_nxt = {acc[30:0], !diff[33]};

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{32{rs_neg}}, rs_data_i};
    assign ext_b     = {{32{rt_neg}}, rt_data_i};
    assign fast_prod = ext_a * ext_b;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            rem   <= '0;
            opb   <= '0;
            count <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            div0  <= 1'b0;
        end else begin
            if (valid_i && !stall_o) begin
                if (alu_op_i == OP_MTHI) hi <= rs_data_i;
                if (alu_op_i == OP_MTLO) lo <= rs_data_i;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        neg_a <= rs_neg;
                        neg_b <= rt_neg;
                        div0  <= (rt_data_i == 32'd0);
                        count <= '0;
                        if (is_div) begin
                            rem   <= '0;
                            acc   <= {32'd0, rs_mag};
                            opb   <= rt_mag;
                            state <= DIV;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else begin
                            hi    <= fast_prod[63:32];
                            lo    <= fast_prod[31:0];
                            state <= DONE;
                        end
`else
                        else begin
                            acc   <= {32'd0, rt_mag};
                            opb   <= rs_mag;
                            state <= MUL;
                        end
`endif
                    end
                end
                MUL: begin
                    acc   <= acc_mul;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        state <= DONE;
                    end
                end
                DIV: begin
                    rem   <= rem_nxt;
                    acc   <= {acc[63:32], quo_nxt};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        // Remainder takes the dividend sign, so x/0 leaves HI = x.
                        hi    <= neg_a ? -rem_nxt[31:0] : rem_nxt[31:0];
                        lo    <= div0 ? 32'hFFFF_FFFF
                               : ((neg_a ^ neg_b) ? -quo_nxt : quo_nxt);
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

    always_comb begin
        result_o = '0;
        if (alu_op_i == OP_MFHI) result_o = hi;
        if (alu_op_i == OP_MFLO) result_o = lo;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: HI/LO results, stall timing, reset abort.
// Honours MULDIV_FAST_MUL_EN for the expected MULT/MULTU stall length.
module tb_ex_muldiv;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [5:0]  alu_op_i = '0;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        stall_o;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail = 0;

    ex_muldiv dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .alu_op_i  (alu_op_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .stall_o   (stall_o),
        .result_o  (result_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, hold it while stalled, return the stalled cycle count.
    // Returns during the first unstalled (DONE) cycle.
    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          output int stalls);
        stalls = 0;
        @(negedge clk);
        valid_i   = 1'b1;
        alu_op_i  = op;
        rs_data_i = a;
        rt_data_i = b;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall_o) break;
            stalls++;
            @(negedge clk);
        end
        check({tag, "_busy_done"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        valid_i  = 1'b0;
        alu_op_i = '0;
    endtask

    int st;

    initial begin
        #2;
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
        check("multu_stall", st, MUL_STALL);
        check("multu_hi", hi_o, 32'hFFFF_FFFE);
        check("multu_lo", lo_o, 32'h0000_0001);
        idle();

        run_op("mult", OP_MULT, -32'sd7, 32'd3, st);
        check("mult_stall", st, MUL_STALL);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFEB);
        @(negedge clk);
        alu_op_i = OP_MFLO;
        #1;
        check("mflo_b2b", result_o, 32'hFFFF_FFEB);
        idle();

        run_op("div", OP_DIV, -32'sd7, 32'd2, st);
        check("div_stall", st, DIV_STALL);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);
        idle();

        run_op("divu", OP_DIVU, 32'd100, 32'd7, st);
        check("divu_stall", st, DIV_STALL);
        check("divu_lo", lo_o, 32'd14);
        check("divu_hi", hi_o, 32'd2);
        idle();

        run_op("ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
        check("ovf_lo", lo_o, 32'h8000_0000);
        check("ovf_hi", hi_o, 32'd0);
        idle();

        run_op("divu0", OP_DIVU, 32'd5, 32'd0, st);
        check("divu0_lo", lo_o, 32'hFFFF_FFFF);
        check("divu0_hi", hi_o, 32'd5);
        idle();

        run_op("div0", OP_DIV, -32'sd9, 32'd0, st);
        check("div0_lo", lo_o, 32'hFFFF_FFFF);
        check("div0_hi", hi_o, 32'hFFFF_FFF7);
        idle();

        // MTLO write becomes visible one cycle later
        @(negedge clk);
        valid_i   = 1'b1;
        alu_op_i  = OP_MTLO;
        rs_data_i = 32'h0000_ABCD;
        idle();
        #1;
        check("mtlo", lo_o, 32'h0000_ABCD);

        @(negedge clk);
        valid_i   = 1'b1;
        alu_op_i  = OP_MTHI;
        rs_data_i = 32'h0000_1234;
        @(negedge clk);
        alu_op_i = OP_MFHI;
        #1;
        check("mfhi", result_o, 32'h0000_1234);

        @(negedge clk);
        alu_op_i  = OP_MULT;
        rs_data_i = 32'd3;
        rt_data_i = 32'd4;
        repeat (10) @(negedge clk);
        reset   = 1'b1;
        valid_i = 1'b0;
        #1;
        check("abort_hi", hi_o, 32'd0);
        check("abort_lo", lo_o, 32'd0);
        check("abort_stall", {31'd0, stall_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult34", OP_MULT, 32'd3, 32'd4, st);
        check("mult34_stall", st, MUL_STALL);
        check("mult34_lo", lo_o, 32'd12);
        check("mult34_hi", hi_o, 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the execute stage, consuming the issue-execute pipeline register outputs alongside the ALU. It executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over multiple cycles, stalling the pipeline while busy. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
Parameters:
- none; all widths are fixed at 32-bit MIPS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- valid_i  in  1  EX instruction valid (EX pipe register valid)
- alu_op_i  in  6  EX ALU op, MIPS funct encoding
- rs_data_i  in  32  forwarded rs operand
- rt_data_i  in  32  forwarded rt operand
- stall_o  out  1  holds the EX pipe register and all upstream stages
- result_o  out  32  MFHI → HI, MFLO → LO, otherwise 0
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- busy_o  out  1  state is MUL or DIV

## Operation
- Op codes:
  - MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
  - MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B.
  - Any other code is ignored.
- States: IDLE, MUL, DIV, DONE.
- start = valid_i & (op in 6'h18–6'h1B) & state==IDLE.
- IDLE:
  - On start, latch the operand magnitudes, for signed ops take the absolute value of each and record the sign flags, clear the 5-bit count, then go to MUL or DIV.
  - MTHI/MTLO with valid_i & !stall_o writes rs_data_i into HI/LO.
- MUL: shift-add over a 64-bit accumulator, one multiplier bit per cycle.
- DIV: restoring division with a 33-bit partial remainder, one quotient bit per cycle.
- Completion: when count==31, apply the sign correction, write HI/LO, go to DONE.
- DONE: start is suppressed, stall_o is low, and the state unconditionally returns to IDLE next cycle. This stops the still-present MULT/DIV in EX from restarting.
- Signed results:
  - Product is negated when the operand signs differ.
  - Quotient sign = sign(rs) ^ sign(rt); remainder sign = sign(rs).
  - LO = quotient, HI = remainder.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = rs_data_i. This applies to both signed and unsigned.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- valid_i dropping mid-operation does not abort the operation; operands are already latched.
- result_o and hi_o/lo_o are combinational from the HI/LO registers.

## Timing
- Reset values: HI = 0, LO = 0, state = IDLE, count = 0, stall_o = 0, busy_o = 0, result_o = 0.
- stall_o = start | busy_o. It is combinational from valid_i/alu_op_i in the accept cycle.
- MULT/DIV accepted in cycle T:
  - Iterations run in T+1..T+32.
  - HI/LO are updated at the edge ending T+32.
  - stall_o is high T..T+32, and DONE occurs in T+33.
  - The instruction leaves EX at the edge ending T+33, so it occupies EX for 34 cycles.
- An MFHI/MFLO immediately following the op sees the new HI/LO with no bypass needed.
- MTHI/MTLO write at the edge ending the cycle they are valid in EX, with 1-cycle latency to hi_o/lo_o.
- Reset asserted mid-operation aborts immediately. HI/LO return to 0 and the partial result is discarded.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full 64-bit product in the accept cycle and write HI/LO at the edge ending T.
  - The state goes IDLE→DONE, stall_o is high only in T, and the instruction leaves EX after T+1.
  - DIV/DIVU are unchanged.
- MULDIV_FAST_MUL_EN undefined: MULT/MULTU use the 32-iteration MUL state described above.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
  - stall_o high exactly 33 cycles (1 with MULDIV_FAST_MUL_EN).
  - busy_o low in DONE.
- MULT −7 × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - A back-to-back MFLO yields result_o = 0xFFFFFFEB.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- Reset sequence: MTHI 0x1234 then MFHI → result_o = 0x1234.
  - Start MULT 3 × 4, assert reset at iteration 10 → HI = LO = 0, stall_o = 0, state IDLE.
  - Then MULT 3 × 4 completes with LO = 12.
